jtopl_mmr: RTL

Bus-side register write decoder for the OPL core: accepts CPU address/data port writes, decodes the OPL2 register map, and drives the per-slot update interface (`sel_group`, `sel_sub`, `write`, `up_*`, held data byte) consumed by the operator/channel register stage. Global registers (rhythm, depth, wave enable, CSM, timers) are latched here and exported as levels. Per-slot writes are held for a full slot round so the downstream stage sees its matching slot.

---
 rtl/jtopl_mmr.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/jtopl_mmr.sv
// jtopl_mmr: CPU-side register write decoder for the OPL core.
// Detects port writes, latches the OPL2 global registers and holds each
// operator/channel update for a full slot round so the register stage
// sees it on its matching slot.
module jtopl_mmr #(
  parameter int HOLD = 24
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cen,
  input  logic [7:0] i_din,
  input  logic       i_addr,
  input  logic       i_cs_n,
  input  logic       i_wr_n,
  output logic [7:0] o_reg_din,
  output logic [1:0] o_sel_group,
  output logic [2:0] o_sel_sub,
  output logic       o_write,
  output logic       o_up_mult,
  output logic       o_up_ksl_tl,
  output logic       o_up_ar_dr,
  output logic       o_up_sl_rr,
  output logic       o_up_wav,
  output logic       o_up_fnumlo,
  output logic       o_up_fnumhi,
  output logic       o_up_fbcon,
  output logic       o_busy,
  output logic       o_wave_mode,
  output logic       o_csm,
  output logic       o_note_sel,
  output logic       o_am_dep,
  output logic       o_vib_dep,
  output logic       o_rhy_en,
  output logic [4:0] o_rhy_kon,
  output logic [7:0] o_value_A,
  output logic [7:0] o_value_B,
  output logic       o_load_A,
  output logic       o_load_B,
  output logic       o_flagen_A,
  output logic       o_flagen_B,
  output logic       o_clr_flag
);

  typedef enum logic { S_IDLE, S_HOLD } state_t;

  state_t      r_state, w_state_nx;
  logic [4:0]  r_cnt, w_cnt_nx;
  logic        r_armed, w_armed_nx;
  logic [7:0]  r_up, w_up_nx;     // {mult,ksl_tl,ar_dr,sl_rr,wav,fnumlo,fnumhi,fbcon}
  logic [1:0]  r_grp, w_grp_nx;
  logic [2:0]  r_sub, w_sub_nx;
  logic [7:0]  r_sel_addr;
  logic        r_wr_prev;

  logic        w_wr, w_acc, w_acc_addr, w_acc_data;
  logic        w_op_ok, w_ch_ok, w_slot_wr;
  logic [7:0]  w_up_dec;
  logic [1:0]  w_grp_dec;
  logic [2:0]  w_sub_dec;

  // Strobe edge detect: a held-low strobe counts as one write
  assign w_wr       = !i_cs_n && !i_wr_n;
  assign w_acc      = w_wr && !r_wr_prev;
  assign w_acc_addr = w_acc && !i_addr;
  assign w_acc_data = w_acc &&  i_addr;

  // Decode the latched address into a per-slot target
  always_comb begin
    w_op_ok   = 1'b0;
    w_ch_ok   = 1'b0;
    w_up_dec  = 8'd0;
    w_grp_dec = 2'd0;
    w_sub_dec = 3'd0;
    // operator ranges: 18 slots laid out as 3 groups of 6 with holes
    if (r_sel_addr[2:0] <= 3'd5 && r_sel_addr[4:3] != 2'd3) begin
      w_grp_dec = r_sel_addr[4:3];
      w_sub_dec = r_sel_addr[2:0];
      w_op_ok   = 1'b1;
      case (r_sel_addr[7:5])
        3'd1:    w_up_dec = 8'b1000_0000;
        3'd2:    w_up_dec = 8'b0100_0000;
        3'd3:    w_up_dec = 8'b0010_0000;
        3'd4:    w_up_dec = 8'b0001_0000;
        3'd7:    w_up_dec = 8'b0000_1000;
        default: w_op_ok  = 1'b0;
      endcase
    end
    // channel ranges: 9 channels folded into 3 groups of 3 (0xBD is n=13, rejected)
    if (!w_op_ok && r_sel_addr[3:0] <= 4'd8) begin
      w_ch_ok = 1'b1;
      case (r_sel_addr[7:4])
        4'hA:    w_up_dec = 8'b0000_0100;
        4'hB:    w_up_dec = 8'b0000_0010;
        4'hC:    w_up_dec = 8'b0000_0001;
        default: w_ch_ok  = 1'b0;
      endcase
      case (r_sel_addr[3:0])
        4'd0, 4'd1, 4'd2: begin w_grp_dec = 2'd0; w_sub_dec = 3'(r_sel_addr[3:0]);        end
        4'd3, 4'd4, 4'd5: begin w_grp_dec = 2'd1; w_sub_dec = 3'(r_sel_addr[3:0] - 4'd3); end
        default:          begin w_grp_dec = 2'd2; w_sub_dec = 3'(r_sel_addr[3:0] - 4'd6); end
      endcase
    end
  end

  assign w_slot_wr = w_acc_data && (w_op_ok || w_ch_ok);

  // Hold FSM next state: a new per-slot write always reloads (last write wins).
  // The first cen after a load only aligns to the slot clock, then HOLD ticks run.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_armed_nx = r_armed;
    w_up_nx    = r_up;
    w_grp_nx   = r_grp;
    w_sub_nx   = r_sub;
    if (w_slot_wr) begin
      w_state_nx = S_HOLD;
      w_cnt_nx   = 5'(HOLD - 1);
      w_armed_nx = 1'b0;
      w_up_nx    = w_up_dec;
      w_grp_nx   = w_grp_dec;
      w_sub_nx   = w_sub_dec;
    end else if (r_state == S_HOLD && i_cen) begin
      if (!r_armed) begin
        w_armed_nx = 1'b1;
      end else if (r_cnt == 5'd0) begin
        w_state_nx = S_IDLE;
        w_up_nx    = 8'd0;
      end else begin
        w_cnt_nx = r_cnt - 5'd1;
      end
    end
  end

  // Hold FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_armed <= 1'b0;
      r_up    <= 8'd0;
      r_grp   <= 2'd0;
      r_sub   <= 3'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_armed <= w_armed_nx;
      r_up    <= w_up_nx;
      r_grp   <= w_grp_nx;
      r_sub   <= w_sub_nx;
    end
  end

  // Bus capture: edge detector, address latch, data byte and one-clk pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_prev  <= 1'b0;
      r_sel_addr <= 8'd0;
      o_reg_din  <= 8'd0;
      o_write    <= 1'b0;
      o_clr_flag <= 1'b0;
    end else begin
      r_wr_prev  <= w_wr;
      o_write    <= w_acc_data;
      o_clr_flag <= w_acc_data && r_sel_addr == 8'h04 && i_din[7];
      if (w_acc_addr) r_sel_addr <= i_din;
      if (w_acc_data) o_reg_din  <= i_din;
    end
  end

  // Global registers, exported as levels
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wave_mode <= 1'b0;
      o_csm       <= 1'b0;
      o_note_sel  <= 1'b0;
      o_am_dep    <= 1'b0;
      o_vib_dep   <= 1'b0;
      o_rhy_en    <= 1'b0;
      o_rhy_kon   <= 5'd0;
      o_value_A   <= 8'd0;
      o_value_B   <= 8'd0;
      o_load_A    <= 1'b0;
      o_load_B    <= 1'b0;
      o_flagen_A  <= 1'b0;
      o_flagen_B  <= 1'b0;
    end else if (w_acc_data) begin
      case (r_sel_addr)
        8'h01: o_wave_mode <= i_din[5];
        8'h02: o_value_A   <= i_din;
        8'h03: o_value_B   <= i_din;
        8'h04: begin
          o_load_A   <= i_din[0];
          o_load_B   <= i_din[1];
          o_flagen_A <= ~i_din[6];
          o_flagen_B <= ~i_din[5];
        end
        8'h08: begin
          o_csm      <= i_din[7];
          o_note_sel <= i_din[6];
        end
        8'hBD: begin
          o_am_dep   <= i_din[7];
          o_vib_dep  <= i_din[6];
          o_rhy_en   <= i_din[5];
          o_rhy_kon  <= i_din[4:0];
        end
        default: ;
      endcase
    end
  end

  assign o_busy      = (r_state == S_HOLD);
  assign o_sel_group = r_grp;
  assign o_sel_sub   = r_sub;
  assign {o_up_mult, o_up_ksl_tl, o_up_ar_dr, o_up_sl_rr,
          o_up_wav, o_up_fnumlo, o_up_fnumhi, o_up_fbcon} = r_up;

endmodule
